// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the FIFO controller.
// Exports the controller state enum and the default AW/DW constants.
package fifo_pkg;

    localparam int FIFO_AW = 4;
    localparam int FIFO_DW = 8;

    // RD_WR: a pop whose accompanying push is still pending.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RD_WR = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external single-port DistMem (16x8) RAM.
// Turns push/pop pulses into serialized RAM write/read cycles.
//
// Ports:
//   clk, rst_n       : clock (rising edge), async active-low reset
//   push, pop, din   : one-cycle requests, accepted only while ready
//   dout, dout_valid : last popped word and its one-cycle strobe
//   ready            : high only in IDLE
//   full, empty      : derived from count
//   count            : occupancy 0..2**AW
//   mem_we/a/d       : DistMem write enable, address, write data
//   mem_spo          : DistMem asynchronous read data
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          ready,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_spo
);

    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [DW-1:0] din_q;
    logic          load_din;
    logic          do_wr;
    logic          do_rd;

    assign ready = (state == IDLE);
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign do_wr = (state == WR);
    assign do_rd = (state == RD) || (state == RD_WR);

    // Next state. A simultaneous push+pop on a full FIFO is legal
    // because the read frees a slot before the write. On an empty
    // FIFO the pop half is dropped and only the push proceeds.
    always_comb begin
        state_nx = state;
        load_din = 1'b0;
        unique case (state)
            IDLE: begin
                if (push && pop && !empty) begin
                    state_nx = RD_WR;
                    load_din = 1'b1;
                end else if (push && !full) begin
                    state_nx = WR;
                    load_din = 1'b1;
                end else if (pop && !push && !empty) begin
                    state_nx = RD;
                end
            end
            WR:      state_nx = IDLE;
            RD:      state_nx = IDLE;
            RD_WR:   state_nx = WR;
            default: state_nx = IDLE;
        endcase
    end

    // RAM port is purely a function of state and pointers, so an
    // asynchronous reset drops mem_we the instant rst_n falls.
    always_comb begin
        mem_we = do_wr;
        mem_a  = do_wr ? wp : rp;
        mem_d  = din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
        end else if (load_din) begin
            din_q <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_wr) begin
                wp <= wp + PTR_ONE;
            end
            if (do_rd) begin
                rp <= rp + PTR_ONE;
            end
        end
    end

    // WR and RD states never coincide, so count moves by one at most.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (do_wr) begin
            count <= count + CNT_ONE;
        end else if (do_rd) begin
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= do_rd;
            if (do_rd) begin
                dout <= mem_spo;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural
// DistMem 16x8 model (synchronous write, asynchronous read).
module tb_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       ready;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       mem_we;
    logic [3:0] mem_a;
    logic [7:0] mem_d;
    logic [7:0] mem_spo;

    logic [7:0] ram [16];
    int         wcnt;
    int         vcnt;
    int         npass;
    int         ntotal;

    fifo_ctrl #(.AW(4), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ready      (ready),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .mem_spo    (mem_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_spo = ram[mem_a];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_a] <= mem_d;
            wcnt <= wcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (dout_valid === 1'b1) vcnt <= vcnt + 1;
    end

    task automatic do_push(input logic [7:0] d);
        @(negedge clk);
        push = 1'b1;
        din  = d;
        @(negedge clk);
        push = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_pop(output logic v, output logic [7:0] q);
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        @(negedge clk);
        v = dout_valid;
        q = dout;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ntotal += 7;
        if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty);
        else npass++;
        if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full);
        else npass++;
        if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count);
        else npass++;
        if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout);
        else npass++;
        if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready);
        else npass++;
        if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we);
        else npass++;
        if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_valid);
        else npass++;
    endtask

    task automatic test_basic;
        logic [7:0] exp [3];
        logic       v;
        logic [7:0] q;
        int         vb;
        exp[0] = 8'h11;
        exp[1] = 8'h22;
        exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) do_push(exp[i]);
        ntotal++;
        if (count !== 5'd3) $display("FAIL basic_count got %0d want 3", count);
        else npass++;
        #1 vb = vcnt;
        for (int i = 0; i < 3; i++) begin
            do_pop(v, q);
            ntotal += 2;
            if (v !== 1'b1) $display("FAIL basic_valid%0d got %b want 1", i, v);
            else npass++;
            if (q !== exp[i]) $display("FAIL basic_dout%0d got %h want %h", i, q, exp[i]);
            else npass++;
        end
        #1;
        ntotal += 2;
        if (vcnt - vb !== 3) $display("FAIL basic_pulses got %0d want 3", vcnt - vb);
        else npass++;
        if (empty !== 1'b1) $display("FAIL basic_empty got %b want 1", empty);
        else npass++;
    endtask

    task automatic test_full_wrap;
        logic       v;
        logic [7:0] q;
        for (int i = 0; i < 16; i++) do_push(8'(i));
        ntotal += 2;
        if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full);
        else npass++;
        if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count);
        else npass++;
        @(negedge clk);
        push = 1'b1;
        din  = 8'hFF;
        @(negedge clk);
        push = 1'b0;
        ntotal++;
        if (ready !== 1'b1) $display("FAIL full_drop_ready got %b want 1", ready);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (count !== 5'd16) $display("FAIL full_drop_count got %0d want 16", count);
        else npass++;
        for (int i = 0; i < 16; i++) begin
            do_pop(v, q);
            ntotal++;
            if (v !== 1'b1 || q !== 8'(i))
                $display("FAIL full_pop%0d got v=%b %h want v=1 %h", i, v, q, 8'(i));
            else npass++;
        end
        ntotal++;
        if (empty !== 1'b1) $display("FAIL full_drained got %b want 1", empty);
        else npass++;
    endtask

    task automatic test_pop_empty;
        logic       v;
        logic [7:0] q;
        int         vb;
        // wp and rp both sit at 3 after the earlier 3 + 16 operations.
        ntotal++;
        if (mem_a !== 4'd3) $display("FAIL pe_rp_before got %0d want 3", mem_a);
        else npass++;
        #1 vb = vcnt;
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        ntotal++;
        if (ready !== 1'b1) $display("FAIL pe_ready got %b want 1", ready);
        else npass++;
        @(negedge clk);
        #1;
        ntotal += 3;
        if (vcnt !== vb) $display("FAIL pe_valid got %0d pulses want 0", vcnt - vb);
        else npass++;
        if (count !== 5'd0) $display("FAIL pe_count got %0d want 0", count);
        else npass++;
        if (mem_a !== 4'd3) $display("FAIL pe_rp_after got %0d want 3", mem_a);
        else npass++;
        @(negedge clk);
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'h5A;
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        ntotal++;
        if (mem_we !== 1'b1) $display("FAIL pp_empty_we got %b want 1", mem_we);
        else npass++;
        @(negedge clk);
        #1;
        ntotal += 2;
        if (count !== 5'd1) $display("FAIL pp_empty_count got %0d want 1", count);
        else npass++;
        if (vcnt !== vb) $display("FAIL pp_empty_valid got %0d pulses want 0", vcnt - vb);
        else npass++;
        do_pop(v, q);
        ntotal++;
        if (v !== 1'b1 || q !== 8'h5A)
            $display("FAIL pp_empty_pop got v=%b %h want v=1 5a", v, q);
        else npass++;
    endtask

    task automatic test_full_rdwr;
        logic       v;
        logic [7:0] q;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) do_push(8'h40 + 8'(i));
        @(negedge clk);
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'hA5;
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        ntotal += 2;
        if (ready !== 1'b0) $display("FAIL rw_ready0 got %b want 0", ready);
        else npass++;
        if (count !== 5'd16) $display("FAIL rw_count0 got %0d want 16", count);
        else npass++;
        @(negedge clk);
        ntotal += 6;
        if (dout !== 8'h40) $display("FAIL rw_head got %h want 40", dout);
        else npass++;
        if (dout_valid !== 1'b1) $display("FAIL rw_valid got %b want 1", dout_valid);
        else npass++;
        if (count !== 5'd15) $display("FAIL rw_count1 got %0d want 15", count);
        else npass++;
        if (ready !== 1'b0) $display("FAIL rw_ready1 got %b want 0", ready);
        else npass++;
        if (mem_we !== 1'b1) $display("FAIL rw_we got %b want 1", mem_we);
        else npass++;
        if (mem_d !== 8'hA5) $display("FAIL rw_memd got %h want a5", mem_d);
        else npass++;
        @(negedge clk);
        ntotal += 3;
        if (count !== 5'd16) $display("FAIL rw_count2 got %0d want 16", count);
        else npass++;
        if (ready !== 1'b1) $display("FAIL rw_ready2 got %b want 1", ready);
        else npass++;
        if (dout_valid !== 1'b0) $display("FAIL rw_valid2 got %b want 0", dout_valid);
        else npass++;
        for (int i = 0; i < 16; i++) begin
            e = (i == 15) ? 8'hA5 : 8'h41 + 8'(i);
            do_pop(v, q);
            ntotal++;
            if (v !== 1'b1 || q !== e)
                $display("FAIL rw_drain%0d got v=%b %h want v=1 %h", i, v, q, e);
            else npass++;
        end
    endtask

    task automatic test_reset_mid_wr;
        logic       v;
        logic [7:0] q;
        int         w0;
        @(negedge clk);
        push = 1'b1;
        din  = 8'h77;
        @(negedge clk);
        push = 1'b0;
        ntotal++;
        if (mem_we !== 1'b1) $display("FAIL mr_in_wr got %b want 1", mem_we);
        else npass++;
        w0 = wcnt;
        #2 rst_n = 1'b0;
        #1;
        ntotal += 3;
        if (mem_we !== 1'b0) $display("FAIL mr_we got %b want 0", mem_we);
        else npass++;
        if (count !== 5'd0) $display("FAIL mr_count got %0d want 0", count);
        else npass++;
        if (ready !== 1'b1) $display("FAIL mr_ready got %b want 1", ready);
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        ntotal++;
        if (wcnt !== w0) $display("FAIL mr_ramwrite got %0d writes want 0", wcnt - w0);
        else npass++;
        do_pop(v, q);
        ntotal += 2;
        if (v !== 1'b0) $display("FAIL mr_pop_valid got %b want 0", v);
        else npass++;
        if (count !== 5'd0) $display("FAIL mr_pop_count got %0d want 0", count);
        else npass++;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        wcnt   = 0;
        vcnt   = 0;
        rst_n  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        din    = 8'h00;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset();
        test_basic();
        test_full_wrap();
        test_pop_empty();
        test_full_rdwr();
        test_reset_mid_wr();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

FIFO controller that sits directly upstream of the `DistMem` 16×8 distributed RAM and owns its `we`/`a`/`d` inputs and `spo` output. It turns push/pop request pulses into single-port write and read cycles, keeps the read/write pointers and the occupancy count, and presents popped data with a valid strobe. Because the RAM has one address port, push and pop are serialized by a small FSM.

## Interface
- `AW`, 4: RAM address width; depth `DEPTH = 2**AW` (16)
- `DW`, 8: data width
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `push` input 1: one-cycle write request; `din` is sampled with it
- `pop` input 1: one-cycle read request
- `din` input DW: write data
- `dout` output DW: last popped word, registered
- `dout_valid` output 1: one-cycle pulse when `dout` updates
- `ready` output 1: high only in IDLE; requests are accepted only when `ready` is high
- `full` output 1: `count == DEPTH`
- `empty` output 1: `count == 0`
- `count` output AW+1: occupancy, 0..DEPTH
- `mem_we` output 1: drives DistMem `we`
- `mem_a` output AW: drives DistMem `a`
- `mem_d` output DW: drives DistMem `d`
- `mem_spo` input DW: DistMem asynchronous read data

## Operation
- FSM states: IDLE, WR, RD, RD_WR (pop then push pending).
- IDLE, request sampled at an edge:
  - push only, `!full`: latch `din` into `din_q`, go to WR.
  - pop only, `!empty`: go to RD.
  - push and pop, `!empty`: latch `din`, go to RD_WR. Full is allowed here, because the pop frees a slot first.
  - push and pop, `empty`: pop is rejected, push is accepted, go to WR.
  - push when full (no pop), pop when empty, and any request while `!ready`: silently dropped, no state change.
- WR (one cycle):
  - `mem_we=1`, `mem_a=wp`, `mem_d=din_q`.
  - At the closing edge: `wp++`, `count++`, go to IDLE.
- RD (one cycle):
  - `mem_we=0`, `mem_a=rp`.
  - At the closing edge: `dout<=mem_spo`, `rp++`, `count--`, `dout_valid<=1`, go to IDLE.
- RD_WR: behaves exactly as RD, then goes to WR instead of IDLE.
- Pointers are AW bits wide and wrap 15→0 naturally. `count` is AW+1 bits wide and is the only source of `full` and `empty`.
- Outside WR, `mem_we=0`, `mem_a=rp`, `mem_d=din_q`. `mem_*` outputs are combinational from state and pointers.
- Reset (async assert, sync release):
  - state=IDLE, `wp=rp=0`, `count=0`, `din_q=0`.
  - `dout=0`, `dout_valid=0`, `mem_we=0`.
  - Therefore `empty=1`, `full=0`, `ready=1`.
  - Reset mid-WR aborts the write; no RAM write occurs once `rst_n` is low.

## Timing
- Request sampled at edge E0. Push: RAM written and `count` updated at E1; `ready` is high again after E1.
- Pop: `dout` and `count` update at E1. `dout_valid` is high for the cycle E1..E2 only.
- Push+pop: read at E1, write at E2, `ready` high after E2. `count` returns to its old value after E2.
- Back-to-back throughput: one operation per 2 cycles (request cycle plus action cycle).
- `full`, `empty` and `count` change only at action edges, never on the request edge.

## Structure
- Shared package `fifo_pkg`: state enum (`IDLE`, `WR`, `RD`, `RD_WR`) and default `AW`/`DW` constants.
- No sub-module. DistMem stays external so the top level and bench wire `fifo_ctrl` to the existing `DistMem`. Pointer, count and FSM logic are all inline.

## Test plan
- Reset, then idle: `empty=1`, `full=0`, `count=0`, `dout=0`, `ready=1`, `mem_we=0`.
- Push 0x11, 0x22, 0x33 (each waiting for `ready`), then pop 3 times: `dout` is 0x11, 0x22, 0x33, one `dout_valid` pulse each; ends with `empty=1`.
- Push 16 words 0x00..0x0F: `full=1`, `count=16`. A 17th push (0xFF) is dropped and `count` stays 16. Pop 16 returns 0x00..0x0F; this also exercises `wp`/`rp` wrap.
- Pop on empty: no `dout_valid`, `count=0`, `rp` unchanged. Simultaneous push 0x5A and pop on empty: push only, `count=1`, no valid pulse.
- Full FIFO, simultaneous push 0xA5 and pop: old head popped at E1, 0xA5 written at E2, `count=16` after E2, `ready` low for 2 cycles. Draining then returns 0xA5 last.
- Assert `rst_n` low during a WR cycle: no RAM write, `count=0` and `ready=1` immediately. A following pop on empty yields nothing.
